// File: rtl/data_memory_wb_pkg.sv
// data_memory_wb_pkg: access-size encodings and store lane-mask helper shared by the data memory.
package data_memory_wb_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    return sz == SIZE_BYTE ? 4'b0001 << off : sz == SIZE_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/data_memory_wb_write_buffer.sv
// data_memory_wb_write_buffer: circular store FIFO with paced drain and youngest-entry per-lane forwarding.
module data_memory_wb_write_buffer #(
  parameter int AW = 8,
  parameter int DEPTH = 4,
  parameter int DRAIN = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [3:0]    push_be,
  input  logic [31:0]   push_data,
  output logic          full,
  output logic          empty,
  output logic          pop,
  output logic [AW-1:0] pop_addr,
  output logic [3:0]    pop_be,
  output logic [31:0]   pop_data,
  input  logic [AW-1:0] look_addr,
  output logic [31:0]   fwd_data,
  output logic [3:0]    fwd_hit
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = DRAIN > 1 ? $clog2(DRAIN) : 1;
  logic [AW-1:0] e_addr [DEPTH];
  logic [3:0]    e_be   [DEPTH];
  logic [31:0]   e_data [DEPTH];
  logic [PW-1:0] head, tail, k;
  logic [CW-1:0] count;
  logic [DW-1:0] dcnt;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full     = count == CW'(DEPTH);
  assign empty    = count == '0;
  assign pop      = !empty && dcnt == DW'(DRAIN - 1);
  assign pop_addr = e_addr[head];
  assign pop_be   = e_be[head];
  assign pop_data = e_data[head];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      dcnt  <= '0;
    end else begin
      if (push) tail <= nxt(tail);
      if (pop) head <= nxt(head);
      count <= count + CW'(push) - CW'(pop);
      dcnt  <= (empty || pop) ? '0 : dcnt + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) begin
      e_addr[tail] <= push_addr;
      e_be[tail]   <= push_be;
      e_data[tail] <= push_data;
    end
  // Walk oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    fwd_data = '0;
    fwd_hit  = '0;
    k        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      k = PW'((int'(head) + i) % DEPTH);
      if (i < int'(count) && e_addr[k] == look_addr)
        for (int l = 0; l < 4; l++)
          if (e_be[k][l]) begin
            fwd_data[8*l +: 8] = e_data[k][8*l +: 8];
            fwd_hit[l]         = 1'b1;
          end
    end
  end
endmodule

// File: rtl/data_memory_wb.sv
// data_memory_wb: byte-addressable little-endian data memory with posted write buffer and load forwarding.
module data_memory_wb
  import data_memory_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WB_DEPTH = 4,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        stall,
  output logic        wb_empty
);
  localparam int WA = ADDR_WIDTH - 2;
  logic [7:0]    bytes [0:2**ADDR_WIDTH-1];
  logic [WA-1:0] wa, c_addr;
  logic [3:0]    c_be, f_hit;
  logic [31:0]   c_data, f_data, wd, word, res;
  logic [7:0]    b;
  logic [15:0]   h;
  logic          full, push, c_pop, unused_hi;
  assign unused_hi  = ^addr[31:ADDR_WIDTH];
  assign wa         = addr[ADDR_WIDTH-1:2];
  assign misaligned = (mem_read | mem_write) & (size == SIZE_ILL | (size == SIZE_HALF & addr[0]) |
                      (size == SIZE_WORD & |addr[1:0]));
  assign stall      = mem_write & full;
  assign push       = mem_write & !misaligned & !full;
  assign wd         = size == SIZE_BYTE ? {4{write_data[7:0]}} :
                      size == SIZE_HALF ? {2{write_data[15:0]}} : write_data;
  data_memory_wb_write_buffer #(.AW(WA), .DEPTH(WB_DEPTH), .DRAIN(DRAIN_CYCLES)) u_wb (
    .clk(clk), .reset(reset), .push(push), .push_addr(wa), .push_be(lane_mask(size, addr[1:0])),
    .push_data(wd), .full(full), .empty(wb_empty), .pop(c_pop), .pop_addr(c_addr), .pop_be(c_be),
    .pop_data(c_data), .look_addr(wa), .fwd_data(f_data), .fwd_hit(f_hit)
  );
  always_ff @(posedge clk)
    if (c_pop)
      for (int l = 0; l < 4; l++)
        if (c_be[l]) bytes[{c_addr, 2'(l)}] <= c_data[8*l +: 8];
  always_comb begin
    word = '0;
    for (int l = 0; l < 4; l++)
      word[8*l +: 8] = f_hit[l] ? f_data[8*l +: 8] : bytes[{wa, 2'(l)}];
  end
  assign b         = word[{addr[1:0], 3'b000} +: 8];
  assign h         = word[{addr[1], 4'b0000} +: 16];
  assign res       = size == SIZE_BYTE ? {{24{sign_ext & b[7]}}, b} :
                     size == SIZE_HALF ? {{16{sign_ext & h[15]}}, h} : word;
  assign read_data = mem_read & !misaligned ? res : '0;
endmodule

// File: tb/tb_data_memory_wb.sv
// tb_data_memory_wb: directed checks of stores, loads, forwarding, stall, faults and reset discard.
module tb_data_memory_wb;
  import data_memory_wb_pkg::*;
  logic        clk, reset, mw, mr, sel, se;
  logic [1:0]  sz;
  logic [31:0] ad, wd, a_rd, b_rd;
  logic        a_mis, a_stall, a_empty, b_mis, b_stall, b_empty;
  int          checks = 0, errors = 0, n;
  data_memory_wb u0 (
    .clk(clk), .reset(reset), .mem_write(mw & !sel), .mem_read(mr & !sel), .size(sz), .sign_ext(se),
    .addr(ad), .write_data(wd), .read_data(a_rd), .misaligned(a_mis), .stall(a_stall), .wb_empty(a_empty)
  );
  data_memory_wb #(.WB_DEPTH(2), .DRAIN_CYCLES(4)) u1 (
    .clk(clk), .reset(reset), .mem_write(mw & sel), .mem_read(mr & sel), .size(sz), .sign_ext(se),
    .addr(ad), .write_data(wd), .read_data(b_rd), .misaligned(b_mis), .stall(b_stall), .wb_empty(b_empty)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem0(input int a);
    return {u0.bytes[a+3], u0.bytes[a+2], u0.bytes[a+1], u0.bytes[a]};
  endfunction
  function automatic logic [31:0] mem1(input int a);
    return {u1.bytes[a+3], u1.bytes[a+2], u1.bytes[a+1], u1.bytes[a]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask
  task automatic st(input bit s, input logic [1:0] z, input int a, input logic [31:0] d);
    sel = s; mw = 1'b1; sz = z; ad = a; wd = d;
    cyc(1);
    mw = 1'b0;
  endtask
  task automatic ld(input string tag, input bit s, input logic [1:0] z, input bit e, input int a,
                    input logic [31:0] exp);
    sel = s; mr = 1'b1; sz = z; se = e; ad = a;
    #1;
    chk(tag, s ? b_rd : a_rd, exp);
    mr = 1'b0;
  endtask
  task automatic wait_empty(input string tag, input bit s);
    int c = 0;
    while (!(s ? b_empty : a_empty) && c < 50) begin
      cyc(1);
      c++;
    end
    chk(tag, 32'(s ? b_empty : a_empty), 32'd1);
  endtask
  initial begin
    reset = 1'b1; mw = 0; mr = 0; sel = 0; se = 0; sz = SIZE_WORD; ad = 0; wd = 0;
    cyc(2);
    reset = 1'b0;
    chk("rst_stall", 32'(a_stall), 0);
    chk("rst_empty0", 32'(a_empty), 1);
    chk("rst_empty1", 32'(b_empty), 1);
    chk("rst_rd_idle", a_rd, 0);
    st(0, SIZE_WORD, 8, 32'd4);
    chk("sw_pending", 32'(a_empty), 0);
    cyc(1);
    chk("sw_drained", 32'(a_empty), 1);
    chk("sw_bytes8", mem0(8), 32'h0000_0004);
    st(0, SIZE_WORD, 16, 32'hFFFF_FFFF);
    st(0, SIZE_BYTE, 16, 32'h0000_00AA);
    ld("lbu_fwd", 0, SIZE_BYTE, 0, 16, 32'h0000_00AA);
    cyc(1);
    chk("sb_bytes16", mem0(16), 32'hFFFF_FFAA);
    ld("lb16", 0, SIZE_BYTE, 1, 16, 32'hFFFF_FFAA);
    ld("lbu16", 0, SIZE_BYTE, 0, 16, 32'h0000_00AA);
    st(0, SIZE_WORD, 24, 32'hFFFF_FFFF);
    st(0, SIZE_HALF, 24, 32'h0000_BEEF);
    cyc(1);
    chk("sh_bytes24", mem0(24), 32'hFFFF_BEEF);
    ld("lh24", 0, SIZE_HALF, 1, 24, 32'hFFFF_BEEF);
    ld("lhu24", 0, SIZE_HALF, 0, 24, 32'h0000_BEEF);
    ld("lb25", 0, SIZE_BYTE, 1, 25, 32'hFFFF_FFBE);
    ld("lhu26", 0, SIZE_HALF, 0, 26, 32'h0000_FFFF);
    ld("lw_wrap", 0, SIZE_WORD, 0, 32'h0000_0408, 32'h0000_0004);
    sel = 0; mw = 1; sz = SIZE_HALF; ad = 32'h11; wd = 32'h1234;
    #1;
    chk("sh_mis", 32'(a_mis), 1);
    cyc(1);
    mw = 0;
    chk("sh_mis_drop", 32'(a_empty), 1);
    ld("lw_mis_rd", 0, SIZE_WORD, 0, 32'h22, 0);
    mr = 1; ad = 32'h22;
    #1;
    chk("lw_mis", 32'(a_mis), 1);
    sz = SIZE_ILL; ad = 0;
    #1;
    chk("ill_mis", 32'(a_mis), 1);
    chk("ill_rd", a_rd, 0);
    mr = 0;
    st(1, SIZE_WORD, 32, 0);
    wait_empty("pre32", 1);
    st(1, SIZE_WORD, 32, 32'h1122_3344);
    st(1, SIZE_BYTE, 33, 32'h0000_0055);
    ld("lw_fwd2", 1, SIZE_WORD, 0, 32, 32'h1122_5544);
    chk("old32", mem1(32), 0);
    wait_empty("drain32", 1);
    chk("new32", mem1(32), 32'h1122_5544);
    sel = 1; mw = 1; sz = SIZE_WORD; ad = 40; wd = 32'hA1A1_A1A1;
    cyc(1);
    ad = 44; wd = 32'hB2B2_B2B2;
    cyc(1);
    ad = 40; wd = 32'hC3C3_C3C3;
    chk("stall_on", 32'(b_stall), 1);
    n = 0;
    while (b_stall && n < 20) begin
      cyc(1);
      n++;
    end
    chk("stall_cycles", n, 3);
    chk("first_commit", mem1(40), 32'hA1A1_A1A1);
    cyc(1);
    mw = 0;
    wait_empty("drain3", 1);
    chk("order40", mem1(40), 32'hC3C3_C3C3);
    chk("order44", mem1(44), 32'hB2B2_B2B2);
    st(1, SIZE_WORD, 56, 0);
    st(1, SIZE_WORD, 60, 0);
    wait_empty("pre56", 1);
    st(1, SIZE_WORD, 56, 32'hDEAD_BEEF);
    st(1, SIZE_WORD, 60, 32'hCAFE_F00D);
    chk("pend2", 32'(b_empty), 0);
    reset = 1; sel = 1; mw = 1; sz = SIZE_WORD; ad = 56;
    #1;
    chk("rst_mid_empty", 32'(b_empty), 1);
    chk("rst_mid_stall", 32'(b_stall), 0);
    mw = 0;
    cyc(1);
    reset = 0;
    cyc(10);
    chk("discard56", mem1(56), 0);
    chk("discard60", mem1(60), 0);
    chk("post_rst_empty", 32'(b_empty), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
